// File: rtl/tube_pkg.sv
// Shared constants, state encoding and index helpers for the tube display scheduler.
package tube_pkg;

    localparam int NREQ  = 3;
    localparam int DIN_W = 32;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    // (a + b) mod NREQ for indices already in range.
    function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tube_rr_pick.sv
// Round-robin search: first set request bit starting at ptr, wrapping 2->0.
module tube_rr_pick
    import tube_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            valid,
    output logic [1:0]      winner
);

    logic [1:0] cand;

    // Walk from the farthest candidate back to ptr so the closest one wins.
    always_comb begin
        valid  = 1'b0;
        winner = 2'd0;
        cand   = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = wrap_add(ptr, i[1:0]);
            if (req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/tube_disp_sched.sv
// Three-requester display scheduler: round-robin grant, fixed dwell, latched display word.
// Optional feature: define TUBE_SCHED_PREEMPT_EN to let a rising req[0] preempt requesters 1/2.
module tube_disp_sched
    import tube_pkg::*;
#(
    parameter logic [31:0] DWELL_CYC = 32'd50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [31:0]      data0,
    input  logic [31:0]      data1,
    input  logic [31:0]      data2,
    output logic [2:0]       gnt,
    output logic [2:0]       done,
    output logic [31:0]      dout,
    output logic             busy
);

    localparam logic [31:0] LAST_CNT = DWELL_CYC - 32'd1;

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       win_q, win_d;
    logic [DIN_W-1:0] dout_q, dout_d;
    logic [NREQ-1:0]  done_q, done_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [DIN_W-1:0] pick_data;
    logic             preempt;
    logic             keep_ptr;

    tube_rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        case (pick_idx)
            2'd1:    pick_data = data1;
            2'd2:    pick_data = data2;
            default: pick_data = data0;
        endcase
    end

`ifdef TUBE_SCHED_PREEMPT_EN
    logic req0_q, req0_d;
    logic hold_q, hold_d;

    assign req0_d   = req[0];
    assign preempt  = (state_q == SHOW) && (win_q != 2'd0) && req[0] && !req0_q;
    assign keep_ptr = hold_q;

    // hold_q remembers that ptr was parked on a preempted requester, so
    // requester 0's completion must not advance it.
    always_comb begin
        hold_d = hold_q;
        if (preempt) begin
            hold_d = 1'b1;
        end else if ((state_q == SHOW) && (cnt_q == LAST_CNT)) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_q <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            req0_q <= req0_d;
            hold_q <= hold_d;
        end
    end
`else
    assign preempt  = 1'b0;
    assign keep_ptr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        dout_d  = dout_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SHOW;
                    win_d   = pick_idx;
                    dout_d  = pick_data;
                    cnt_d   = 32'd0;
                end
            end
            SHOW: begin
                if (preempt) begin
                    win_d  = 2'd0;
                    dout_d = data0;
                    cnt_d  = 32'd0;
                    ptr_d  = win_q;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                    done_d  = idx_onehot(win_q);
                    ptr_d   = keep_ptr ? ptr_q : wrap_add(win_q, 2'd1);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            ptr_q   <= 2'd0;
            win_q   <= 2'd0;
            dout_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = (state_q == SHOW) ? idx_onehot(win_q) : 3'b000;
    assign busy = |gnt;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_tube_disp_sched.sv
// Scoreboarded random bench for tube_disp_sched with a grant-level round-robin model.
module tb_tube_disp_sched;

    localparam int DWELL = 4;
    localparam int EW    = 39;  // {done_exp, idx[1:0], data[31:0], len[3:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [31:0] data0 = '0, data1 = '0, data2 = '0;
    logic [2:0]  gnt, done;
    logic [31:0] dout;
    logic        busy;

    logic [EW-1:0] exp_q[$];
    logic [1:0]    ptr_m = 2'd0;
    logic [31:0]   idle_word = '0;
    int            checks = 0;
    int            errors = 0;

    tube_disp_sched #(.DWELL_CYC(32'd4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .gnt   (gnt),
        .done  (done),
        .dout  (dout),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] oh(input logic [1:0] i);
        logic [2:0] one;
        one = 3'b001;
        return one << i;
    endfunction

    function automatic logic [1:0] model_pick(input logic [2:0] r, input logic [1:0] p);
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = (int'(p) + i) % 3;
            if (r[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic          in_show = 1'b0;
    logic          ended;
    logic [1:0]    cur_idx;
    int            cur_len;
    logic [EW-1:0] cur;

    always @(negedge clk) begin
        ended = 1'b0;
        if (in_show && (rst || gnt != oh(cur_idx))) begin
            check("show_len", 64'(cur_len), 64'(cur[3:0]));
            if (!rst && gnt == 3'b000)
                check("done_pulse", 64'(done), 64'(cur[38] ? oh(cur_idx) : 3'b000));
            else
                check("done_quiet", 64'(done), 64'(0));
            in_show = 1'b0;
            ended   = 1'b1;
        end
        if (!rst) begin
            if (in_show) begin
                cur_len++;
                check("dout_hold", 64'(dout), 64'(cur[35:4]));
                check("busy_show", 64'(busy), 64'(1));
                check("done_in_show", 64'(done), 64'(0));
            end else if (gnt != 3'b000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got gnt=%b, expected no grant", gnt);
                end else begin
                    cur     = exp_q.pop_front();
                    cur_idx = cur[37:36];
                    check("gnt_onehot", 64'(gnt), 64'(oh(cur_idx)));
                    check("dout_latch", 64'(dout), 64'(cur[35:4]));
                    check("busy_start", 64'(busy), 64'(1));
                    in_show   = 1'b1;
                    cur_len   = 1;
                    idle_word = cur[35:4];
                end
            end else begin
                check("dout_idle", 64'(dout), 64'(idle_word));
                check("busy_idle", 64'(busy), 64'(0));
                if (!ended) check("done_idle", 64'(done), 64'(0));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic scramble();
        data0 = $urandom;
        data1 = $urandom;
        data2 = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        req       = 3'b000;
        ptr_m     = 2'd0;
        idle_word = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        req = 3'b000;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called in an IDLE cycle; predicts the next grant from the round-robin rule.
    task automatic grant_period(input logic [2:0] r, input int drop_at,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [1:0]  w;
        logic [31:0] dw;
        req   = r;
        data0 = d0;
        data1 = d1;
        data2 = d2;
        if (r == 3'b000) begin
            @(posedge clk);
            #1;
            return;
        end
        w  = model_pick(r, ptr_m);
        dw = (w == 2'd0) ? d0 : (w == 2'd1) ? d1 : d2;
        exp_q.push_back({1'b1, w, dw, 4'(DWELL)});
        ptr_m = (w == 2'd2) ? 2'd0 : w + 2'd1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= DWELL; c++) begin
            scramble();
            if (c == drop_at) req[w] = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] d2v, d0v;

        do_reset();
        idle_cycles(2);
        check("post_rst_dout", 64'(dout), 64'(0));
        check("post_rst_gnt", 64'(gnt), 64'(0));

        // single requester 1 with a known word, then persistence in idle
        grant_period(3'b010, 0, $urandom, 32'h1234_5678, $urandom);
        idle_cycles(3);

        // all requesting from a fresh pointer
        do_reset();
        for (int k = 0; k < 4; k++) grant_period(3'b111, 0, $urandom, $urandom, $urandom);
        idle_cycles(2);

        // request withdrawn after the first SHOW cycle
        grant_period(3'b010, 2, $urandom, $urandom, $urandom);
        idle_cycles(1);

        for (int k = 0; k < 24; k++)
            grant_period(3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom, $urandom, $urandom);
        idle_cycles(2);

        // reset in SHOW cycle 2 of requester 2
        d2v = $urandom;
        req = 3'b100;
        data2 = d2v;
        exp_q.push_back({1'b0, 2'd2, d2v, 4'd1});
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        do_reset();
        check("abort_dout", 64'(dout), 64'(0));
        grant_period(3'b111, 0, $urandom, $urandom, $urandom);
        idle_cycles(2);

        // req[0] rising while requester 2 is in SHOW cycle 2
        d2v = $urandom;
        d0v = $urandom;
        req = 3'b100;
        data2 = d2v;
`ifdef TUBE_SCHED_PREEMPT_EN
        exp_q.push_back({1'b0, 2'd2, d2v, 4'd2});
`else
        exp_q.push_back({1'b1, 2'd2, d2v, 4'(DWELL)});
        ptr_m = 2'd0;
`endif
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        req = 3'b101;
        data0 = d0v;
`ifdef TUBE_SCHED_PREEMPT_EN
        exp_q.push_back({1'b1, 2'd0, d0v, 4'(DWELL)});
        ptr_m = 2'd2;
        repeat (DWELL + 1) begin
            @(posedge clk); #1;
            scramble();
        end
`else
        repeat (DWELL - 1) begin
            @(posedge clk); #1;
            scramble();
        end
`endif
        grant_period(3'b101, 0, $urandom, $urandom, $urandom);
        grant_period(3'b101, 0, $urandom, $urandom, $urandom);
        idle_cycles(4);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("show_closed", 64'(in_show), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tube_disp_sched.md
TUBE_DISP_SCHED -- requirements
Module: tube_disp_sched

Interface
REQ-001 Parameter DWELL_CYC, default 50_000_000, SHALL set the display dwell per grant in clk cycles (1 s at 50 MHz); legal range 1..2^32-1.
REQ-002 Port clk, input, 1, SHALL be the single clock (50 MHz system clock); all logic SHALL be on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-004 Port req, input, 3, SHALL carry per-requester display requests; bit i = requester i, level-sensitive.
REQ-005 Ports data0/data1/data2, input, 32 each, SHALL carry each requester's 8-digit hex display word.
REQ-006 Port gnt, output, 3, SHALL be one-hot (or zero) and mark the requester currently owning the display.
REQ-007 Port done, output, 3, SHALL pulse bit i high for exactly one cycle when requester i's dwell completes.
REQ-008 Port dout, output, 32, SHALL drive the tube driver's din word.
REQ-009 Port busy, output, 1, SHALL be high whenever gnt is non-zero.

Function
REQ-010 The FSM SHALL have two states: IDLE and SHOW.
REQ-011 In IDLE with req non-zero, the arbiter SHALL pick a winner round-robin, searching from index ptr upward with wrap 2->0.
REQ-012 On the edge after a pick, state SHALL be SHOW, gnt SHALL be one-hot on the winner, and dout SHALL hold that winner's data word, latched on that same edge (req-to-gnt latency = 1 cycle).
REQ-013 Data inputs SHALL be ignored after latching; changes mid-SHOW SHALL NOT affect dout.
REQ-014 SHOW SHALL last exactly DWELL_CYC cycles, counted by a 32-bit counter cleared on entry.
REQ-015 On the edge ending the last SHOW cycle: state SHALL return to IDLE, gnt SHALL go to 0, done[winner] SHALL be 1 for that one cycle, and ptr SHALL become winner+1 mod 3.
REQ-016 Arbitration SHALL occur in the done cycle, so back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-017 Dropping req during SHOW SHALL NOT shorten the dwell; done SHALL still pulse.
REQ-018 dout SHALL hold the last shown word in IDLE (the display persists); it SHALL change only on a new grant or on reset.
REQ-019 With DWELL_CYC=1, SHOW SHALL last one cycle and the grant period SHALL be 2 cycles.
REQ-020 gnt SHALL never have more than one bit set; done and gnt SHALL never be high for the same index in the same cycle.

Reset
REQ-021 While rst is high: state=IDLE, gnt=0, done=0, busy=0, dout=32'h0000_0000, counter=0, ptr=0; all effective immediately without waiting for clk.
REQ-022 A reset asserted mid-SHOW SHALL abort the grant silently with no done pulse; after release, requester 0 SHALL have first priority.

Configuration
REQ-023 With macro TUBE_SCHED_PREEMPT_EN defined, req[0] rising while requester 1 or 2 is in SHOW SHALL preempt it: next edge gnt=3'b001, dout=data0, counter cleared, no done for the preempted requester, and ptr set to the preempted index so it is served next after requester 0.
REQ-024 Without TUBE_SCHED_PREEMPT_EN, req[0] SHALL have no special priority and SHALL wait for normal round-robin.

Structure
REQ-025 A shared package tube_pkg SHALL hold NREQ=3, DIN_W=32 and the state enumeration (IDLE, SHOW).
REQ-026 The round-robin search SHALL be a sub-module tube_rr_pick (inputs req and ptr, outputs valid and a 2-bit winner index), instantiated once.

Verification (DWELL_CYC=4 unless stated)
REQ-027 Assert rst with req=0 -> dout=32'h0, gnt=0, done=0, busy=0 immediately; remain so after release.
REQ-028 req=3'b010, data1=32'h12345678 -> gnt=3'b010 one cycle later, dout=32'h12345678 for 4 cycles, then gnt=0 with done=3'b010 for one cycle; dout remains 32'h12345678.
REQ-029 req=3'b111 held -> grants in order 001,010,100,001 at 5-cycle period, with one IDLE cycle between grants.
REQ-030 req[1] dropped after 1 SHOW cycle -> dwell still 4 cycles and done[1] still pulses.
REQ-031 rst pulsed in SHOW cycle 2 of requester 2 -> gnt=0 and dout=0 asynchronously, with no done; afterwards req=3'b111 grants requester 0 first.
REQ-032 TUBE_SCHED_PREEMPT_EN defined, requester 2 in SHOW cycle 2, req[0] rises -> next edge gnt=3'b001, dout=data0, no done[2]; after done[0], requester 2 is granted next. Without the macro, requester 2 completes first.
